// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM encoding,
// the bundle of pipeline-register controls, and the load-use match helper.
package hazard_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         WAIT_W   = 16;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic idex_we;
      logic exm_we;
      logic mw_we;
      logic ifid_flush;
      logic idex_flush;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_FREEZE = 7'b00000_00;
   localparam pipe_ctl_t CTL_RUN    = 7'b11111_00;
   localparam pipe_ctl_t CTL_FLUSH  = 7'b11111_11;
   // Hold PC and IF/ID, push a bubble into ID/EX, let the load move on.
   localparam pipe_ctl_t CTL_STALL  = 7'b00111_01;

   function automatic logic lu_hit(
      input logic       mem_read,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       use1,
      input logic       use2
   );
      return mem_read && (rd != REG_ZERO) &&
             ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating event counter; a clear wins over a same-cycle increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != {W{1'b1}}))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard controller for the 5-stage pipeline: load-use stall, taken-branch
// flush and memory-wait freeze, with wait timeout and performance counters.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RS1_IFID,
   input  logic [4:0]       RS2_IFID,
   input  logic             UsesRS1_IFID,
   input  logic             UsesRS2_IFID,
   input  logic [4:0]       RDest_IDEX,
   input  logic             MemRead_IDEX,
   input  logic             BranchTaken_EX,
   input  logic             DMemReq_EXM,
   input  logic             DMemReady,
   input  logic             CntClear,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXWrite,
   output logic             EXMWrite,
   output logic             MWWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             InMemWait,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] LoadStallCnt,
   output logic [CNT_W-1:0] FlushCnt,
   output logic [CNT_W-1:0] MemWaitCnt
);

   localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

   hz_state_t         r_state, w_state_nxt;
   logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
   logic              r_timeout;
   logic              w_freeze, w_lu, w_to_hit;
   logic              w_inc_lu, w_inc_br, w_inc_frz;
   pipe_ctl_t         w_ctl;

   assign w_freeze = DMemReq_EXM && !DMemReady;
   assign w_lu     = lu_hit(MemRead_IDEX, RDest_IDEX, RS1_IFID, RS2_IFID,
                            UsesRS1_IFID, UsesRS2_IFID);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      case (r_state)
         RUN: begin
            if (w_freeze) begin
               w_state_nxt = MEM_WAIT;
               w_wait_nxt  = {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
               w_wait_nxt  = '0;
            end
         end
         MEM_WAIT: begin
            if (w_freeze) begin
               if (r_wait_cnt < TIMEOUT)
                  w_wait_nxt = r_wait_cnt + 1'b1;
            end else begin
               w_state_nxt = RUN;
               w_wait_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
         end
      endcase
   end

   // Controls depend only on the priority terms: the cycle that leaves
   // MEM_WAIT already has freeze low and falls through to the normal rules.
   always_comb begin
      w_ctl = CTL_RUN;
      if (!rst_n || w_freeze)
         w_ctl = CTL_FREEZE;
      else if (BranchTaken_EX)
         w_ctl = CTL_FLUSH;
      else if (w_lu)
         w_ctl = CTL_STALL;
   end

   assign PCWrite   = w_ctl.pc_we;
   assign IFIDWrite = w_ctl.ifid_we;
   assign IDEXWrite = w_ctl.idex_we;
   assign EXMWrite  = w_ctl.exm_we;
   assign MWWrite   = w_ctl.mw_we;
   assign IFIDFlush = w_ctl.ifid_flush;
   assign IDEXFlush = w_ctl.idex_flush;
   assign InMemWait = (r_state == MEM_WAIT);

   assign w_to_hit = w_freeze && (w_wait_nxt == TIMEOUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_timeout <= 1'b0;
      else if (CntClear)
         r_timeout <= 1'b0;
      else if (w_to_hit)
         r_timeout <= 1'b1;
   end

   assign MemTimeout = r_timeout;

   assign w_inc_frz = w_freeze;
   assign w_inc_br  = !w_freeze && BranchTaken_EX;
   assign w_inc_lu  = !w_freeze && !BranchTaken_EX && w_lu;

   sat_counter #(.W(CNT_W)) u_cnt_lu (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc_lu),
      .i_clr (CntClear),
      .o_cnt (LoadStallCnt)
   );

   sat_counter #(.W(CNT_W)) u_cnt_br (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc_br),
      .i_clr (CntClear),
      .o_cnt (FlushCnt)
   );

   sat_counter #(.W(CNT_W)) u_cnt_frz (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc_frz),
      .i_clr (CntClear),
      .o_cnt (MemWaitCnt)
   );

endmodule
